mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Multi-cycle sequencer for the RV32M ops MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Owns no adder. It time-shares the core's existing 32-bit carry-lookahead adder, which is instantiated in the parent and reached through the ADD_* ports.
- Sits beside the ALU in execute. The core stalls on BUSY and takes RESULT on DONE.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITERS, 32, shift-add / restoring-divide iterations; equals XLEN.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  request; sampled only in IDLE.
- FUNCT3  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- RS1  in  32  multiplicand / dividend.
- RS2  in  32  multiplier / divisor.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse; RESULT is valid.
- RESULT  out  32  registered result; holds until the next DONE.
- ADD_A  out  32  shared adder operand A.
- ADD_B  out  32  shared adder operand B.
- ADD_CIN  out  1  shared adder carry-in.
- ADD_SUM  in  32  shared adder sum, combinational return.

Behaviour:
- Reset (async, RSTN=0): state IDLE; BUSY=0, DONE=0, RESULT=0; all datapath regs 0; cache invalid (if built).
- Reset mid-operation aborts with no DONE.
- ADD_A, ADD_B and ADD_CIN are combinational from state and registers; they are 0 in IDLE and DONE.
- Adder carry-out is derived locally: COUT = (A[31]&B[31]) | ((A[31]^B[31]) & ~SUM[31]).
- Signedness:
  - sa = RS1[31] for MULH, MULHSU, DIV, REM.
  - sb = RS2[31] for MULH, DIV, REM.
  - Otherwise sa and sb are 0; MUL is computed unsigned.
- FSM:
  - IDLE: on START, latch FUNCT3/RS1/RS2/sa/sb -> ABS_A. START while BUSY is ignored.
  - ABS_A: adder computes ~RS1+1 (CIN=1, B=0); keep the result if sa, else keep RS1 -> ABS_B.
  - ABS_B: same for RS2 with sb -> ITER; iteration counter = 0.
  - ITER (32 cycles), multiply:
    - hi' = hi + (lo[0] ? mcand : 0), carry kept as bit 32.
    - {carry, hi', lo} is shifted right by 1.
  - ITER, divide (restoring):
    - Rs = {R, Q[31]} is 33 bits.
    - Adder forms Rs[31:0] + ~D + 1.
    - Subtract is accepted if Rs[32] | COUT; then R = SUM, else R = Rs[31:0].
    - Q is shifted left with the accept bit.
  - ITER exits after count 31 -> FIX1.
  - FIX1:
    - MULH/MULHSU with sa^sb: hi = ~hi + (lo==0).
    - DIV/REM with sa^sb and divisor != 0: Q = ~Q+1.
  - FIX2: DIV/REM with sa: R = ~R+1.
  - DONE: RESULT <= lo (MUL), hi (MULH*), Q (DIV*), R (REM*); DONE=1; -> IDLE.
- Fixed latency: START accepted at edge 0 gives DONE high in cycle 37, with BUSY high for cycles 1..36. Unused fix steps still take their cycle.
- Divide by zero falls out of the algorithm: Q = all ones, R = dividend.
- Overflow 0x80000000 / -1 gives Q = 0x80000000, R = 0, with no special casing.

Optional Feature:
- Macro: MDU_DIVREM_CACHE_EN.
- With the macro defined:
  - After each completed divide, store {RS1, RS2, FUNCT3[0], final Q, final R} and mark the cache valid.
  - A START with FUNCT3[2]=1 and matching RS1, RS2 and FUNCT3[0] goes IDLE->DONE; DONE is high in cycle 2 and BUSY is high in cycle 1 only.
  - Any other divide START runs the full sequence and overwrites the cache on completion.
  - Multiplies leave the cache untouched.
- Without the macro: no cache storage; every op takes 37 cycles.

Decomposition:
- Package mdu_pkg holds:
  - funct3 encoding localparams;
  - state enum IDLE, ABS_A, ABS_B, ITER, FIX1, FIX2, DONE;
  - ITERS constant;
  - COUT derivation as a function.
- No internal sub-module; the adder instance stays in the parent and is muxed there between the ALU and mdu_seq on BUSY.

Test Plan:
- MUL 7 * 6 -> RESULT 0x0000002A, DONE in cycle 37, BUSY high cycles 1..36.
- MULH 0xFFFFFFFF * 0x00000002 -> 0xFFFFFFFF; MULHU same operands -> 0x00000001; MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF; REM 0xFFFFFFFB / 0 -> 0xFFFFFFFB; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- RSTN low at ITER count 10 -> BUSY=DONE=RESULT=0 immediately, no DONE; a START pulse at cycle 5 of a running op is ignored and the result is unchanged.
- MDU_DIVREM_CACHE_EN: DIV -7/2 then REM -7/2 -> second DONE in cycle 2 with 0xFFFFFFFF; REMU -7/2 next -> full 37 cycles.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// mdu_pkg: shared definitions for the RV32M multiply/divide sequencer.
//   MDU_XLEN / MDU_ITERS : datapath width and iteration count (both 32)
//   F3_*                 : RV32M funct3 encodings
//   state_t              : sequencer states
//   add_cout()           : carry-out of the shared adder, rebuilt from MSBs
package mdu_pkg;

    localparam int MDU_XLEN  = 32;
    localparam int MDU_ITERS = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        ABS_A,
        ABS_B,
        ITER,
        FIX1,
        FIX2,
        DONE
    } state_t;

    // The shared adder exposes no carry-out; recover it from the operand
    // and sum MSBs (majority of a, b and carry-into-msb).
    function automatic logic add_cout(input logic a_msb, input logic b_msb,
                                      input logic sum_msb);
        return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~sum_msb);
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request/response and shared-adder signals of mdu_seq.
//   start/funct3/rs1/rs2 : operation request (core -> mdu)
//   busy/done/result     : status and registered result (mdu -> core)
//   add_a/add_b/add_cin  : shared adder operands (mdu -> adder)
//   add_sum              : shared adder sum, combinational (adder -> mdu)
// Modports: slave = mdu_seq side, master = core/parent side.
interface mdu_seq_if;
    import mdu_pkg::*;

    logic                start;
    logic [2:0]          funct3;
    logic [MDU_XLEN-1:0] rs1;
    logic [MDU_XLEN-1:0] rs2;
    logic                busy;
    logic                done;
    logic [MDU_XLEN-1:0] result;
    logic [MDU_XLEN-1:0] add_a;
    logic [MDU_XLEN-1:0] add_b;
    logic                add_cin;
    logic [MDU_XLEN-1:0] add_sum;

    modport slave (
        input  start, funct3, rs1, rs2, add_sum,
        output busy, done, result, add_a, add_b, add_cin
    );

    modport master (
        output start, funct3, rs1, rs2, add_sum,
        input  busy, done, result, add_a, add_b, add_cin
    );

endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
// sequencer. Owns no adder; every add goes through the parent's shared
// adder via bus.add_a/add_b/add_cin -> bus.add_sum.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : mdu_seq_if.slave (request, busy/done/result, shared adder)
// Latency: 37 cycles from accepted start to done.
// Optional: define MDU_DIVREM_CACHE_EN to remember the last divide
// {rs1, rs2, funct3[0], Q, R}; a matching divide finishes in 2 cycles.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN  = MDU_XLEN,
    parameter int ITERS = MDU_ITERS
) (
    input  logic     clk,
    input  logic     rstn,
    mdu_seq_if.slave bus
);

    localparam int CW = $clog2(ITERS);

    state_t          state, state_nx;
    logic [2:0]      op;
    logic            sa, sb;
    logic [XLEN-1:0] rs1_q, rs2_q;
    logic [XLEN-1:0] hi;   // product high / remainder
    logic [XLEN-1:0] lo;   // multiplier->product low / dividend->quotient
    logic [XLEN-1:0] mc;   // |multiplicand| or |divisor|
    logic [CW-1:0]   cnt;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0] add_a, add_b;
    logic            add_cin, cout, accept, is_div, hit;
    logic            sa_in, sb_in;
    logic [XLEN-1:0] rem_fin;

    assign is_div  = op[2];
    assign cout    = add_cout(add_a[XLEN-1], add_b[XLEN-1], bus.add_sum[XLEN-1]);
    assign accept  = hi[XLEN-1] | cout;
    assign rem_fin = sa ? bus.add_sum : hi;

    assign sa_in = bus.rs1[XLEN-1] & ((bus.funct3 == F3_MULH) | (bus.funct3 == F3_MULHSU) |
                                      (bus.funct3 == F3_DIV)  | (bus.funct3 == F3_REM));
    assign sb_in = bus.rs2[XLEN-1] & ((bus.funct3 == F3_MULH) | (bus.funct3 == F3_DIV) |
                                      (bus.funct3 == F3_REM));

    assign bus.add_a   = add_a;
    assign bus.add_b   = add_b;
    assign bus.add_cin = add_cin;
    assign bus.busy    = (state != IDLE) & ~done_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;

`ifdef MDU_DIVREM_CACHE_EN
    logic            c_valid, c_f0;
    logic [XLEN-1:0] c_rs1, c_rs2, c_q, c_r;

    assign hit = bus.funct3[2] & c_valid & (bus.rs1 == c_rs1) &
                 (bus.rs2 == c_rs2) & (bus.funct3[0] == c_f0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_valid <= 1'b0;
            c_f0    <= 1'b0;
            c_rs1   <= '0;
            c_rs2   <= '0;
            c_q     <= '0;
            c_r     <= '0;
        end else if (state == FIX2 && is_div) begin
            c_valid <= 1'b1;
            c_f0    <= op[0];
            c_rs1   <= rs1_q;
            c_rs2   <= rs2_q;
            c_q     <= lo;
            c_r     <= rem_fin;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // DONE is entered either from FIX2 (done_q already set) or directly from
    // IDLE on a cache hit (done_q still clear: spend one busy cycle first).
    always_comb begin
        state_nx = state;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nx = hit ? DONE : ABS_A;
            ABS_A: begin
                add_a    = ~rs1_q;
                add_cin  = 1'b1;
                state_nx = ABS_B;
            end
            ABS_B: begin
                add_a    = ~rs2_q;
                add_cin  = 1'b1;
                state_nx = ITER;
            end
            ITER: begin
                if (is_div) begin
                    add_a   = {hi[XLEN-2:0], lo[XLEN-1]};
                    add_b   = ~mc;
                    add_cin = 1'b1;
                end else begin
                    add_a = hi;
                    add_b = lo[0] ? mc : '0;
                end
                if (cnt == CW'(ITERS - 1)) state_nx = FIX1;
            end
            FIX1: begin
                add_a    = is_div ? ~lo : ~hi;
                add_cin  = is_div ? 1'b1 : (lo == '0);
                state_nx = FIX2;
            end
            FIX2: begin
                add_a    = ~hi;
                add_cin  = 1'b1;
                state_nx = DONE;
            end
            DONE:    state_nx = done_q ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op       <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            hi       <= '0;
            lo       <= '0;
            mc       <= '0;
            cnt      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    op    <= bus.funct3;
                    sa    <= sa_in;
                    sb    <= sb_in;
                    rs1_q <= bus.rs1;
                    rs2_q <= bus.rs2;
                    hi    <= '0;
                    cnt   <= '0;
                end
                // rs1 lands in lo (dividend) for divides, mc (multiplicand) for multiplies.
                ABS_A: begin
                    if (is_div) lo <= sa ? bus.add_sum : rs1_q;
                    else        mc <= sa ? bus.add_sum : rs1_q;
                end
                ABS_B: begin
                    if (is_div) mc <= sb ? bus.add_sum : rs2_q;
                    else        lo <= sb ? bus.add_sum : rs2_q;
                    cnt <= '0;
                end
                ITER: begin
                    if (is_div) begin
                        hi <= accept ? bus.add_sum : {hi[XLEN-2:0], lo[XLEN-1]};
                        lo <= {lo[XLEN-2:0], accept};
                    end else begin
                        hi <= {cout, bus.add_sum[XLEN-1:1]};
                        lo <= {bus.add_sum[0], lo[XLEN-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                end
                FIX1: begin
                    if (is_div) begin
                        if ((sa ^ sb) && mc != '0) lo <= bus.add_sum;
                    end else if ((op == F3_MULH || op == F3_MULHSU) && (sa ^ sb)) begin
                        hi <= bus.add_sum;
                    end
                end
                FIX2: begin
                    hi     <= is_div ? rem_fin : hi;
                    done_q <= 1'b1;
                    if (!is_div) result_q <= (op == F3_MUL) ? lo : hi;
                    else         result_q <= op[1] ? rem_fin : lo;
                end
                DONE: begin
                    done_q <= ~done_q;
`ifdef MDU_DIVREM_CACHE_EN
                    if (!done_q) result_q <= op[1] ? c_r : c_q;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq. Provides the shared
// adder, drives RV32M operations, queues expected results and checks them,
// together with latency and busy/done behaviour, when done fires.
// Honours MDU_DIVREM_CACHE_EN for the expected latency of repeated divides.
module tb_mdu_seq;
    import mdu_pkg::*;

`ifdef MDU_DIVREM_CACHE_EN
    localparam int HIT_LAT = 2;
`else
    localparam int HIT_LAT = 37;
`endif
    localparam int FULL_LAT = 37;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mdu_seq_if bus ();

    assign bus.add_sum = bus.add_a + bus.add_b + {31'b0, bus.add_cin};

    mdu_seq #(.XLEN(32), .ITERS(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // poke != 0: pulse a different start request in that cycle of the op.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input int poke);
        int got_lat;
        logic busy_ok;
        logic [31:0] want;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.rs1    = a;
        bus.rs2    = b;
        exp_q.push_back(exp);
        @(posedge clk);
        got_lat = 0;
        busy_ok = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.start = 1'b0;
            if (poke != 0 && cyc == poke) begin
                bus.start  = 1'b1;
                bus.funct3 = F3_DIVU;
                bus.rs1    = 32'd1;
                bus.rs2    = 32'd1;
            end
            if (poke != 0 && cyc == poke + 1) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                got_lat = cyc;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        want = exp_q.pop_front();
        check({tag, " latency"}, 32'(got_lat), 32'(lat));
        if (got_lat != 0) begin
            check({tag, " result"}, bus.result, want);
            check({tag, " busy_at_done"}, {31'b0, bus.busy}, 32'd0);
            check({tag, " busy_window"}, {31'b0, busy_ok}, 32'd1);
            @(negedge clk);
            check({tag, " done_pulse"}, {31'b0, bus.done}, 32'd0);
            check({tag, " result_hold"}, bus.result, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_done;
        bus.start  = 1'b0;
        bus.funct3 = '0;
        bus.rs1    = '0;
        bus.rs2    = '0;
        #1;
        check("reset busy",   {31'b0, bus.busy}, 32'd0);
        check("reset done",   {31'b0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset add_a",  bus.add_a, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        run_op("MUL 7*6",       F3_MUL,    32'd7,        32'd6,        32'h0000002A, FULL_LAT, 0);
        run_op("MULH -1*2",     F3_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, FULL_LAT, 0);
        run_op("MULHU",         F3_MULHU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, FULL_LAT, 0);
        run_op("MULHSU",        F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, FULL_LAT, 0);
        run_op("DIV -7/2",      F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, FULL_LAT, 0);
        run_op("REM -7/2",      F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, HIT_LAT,  0);
        run_op("REMU -7/2",     F3_REMU,   32'hFFFFFFF9, 32'd2,        32'h00000001, FULL_LAT, 0);
        run_op("DIVU 100/7",    F3_DIVU,   32'd100,      32'd7,        32'd14,       FULL_LAT, 0);
        run_op("REMU 100/7",    F3_REMU,   32'd100,      32'd7,        32'd2,        HIT_LAT,  0);
        run_op("DIV 5/0",       F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, FULL_LAT, 0);
        run_op("REM -5/0",      F3_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, FULL_LAT, 0);
        run_op("DIV ovf",       F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, FULL_LAT, 0);
        run_op("REM ovf",       F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, HIT_LAT,  0);
        run_op("MUL poke",      F3_MUL,    32'd1234,     32'd5678,     32'h006AE9BC, FULL_LAT, 5);
        run_op("REM ovf again", F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, HIT_LAT,  0);
        run_op("MUL -1*-1",     F3_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, FULL_LAT, 0);

        // Abort a divide at ITER count 10 (cycle 13) with an async reset.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = F3_DIV;
        bus.rs1    = 32'hFFFFFFF9;
        bus.rs2    = 32'd2;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("abort busy",   {31'b0, bus.busy}, 32'd0);
        check("abort done",   {31'b0, bus.done}, 32'd0);
        check("abort result", bus.result, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        seen_done = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        check("abort no_done", {31'b0, seen_done}, 32'd0);
        check("abort idle",    {31'b0, bus.busy}, 32'd0);

        run_op("REM ovf post-reset", F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, FULL_LAT, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
